// File: rtl/pipe_pkg.sv
// Shared encodings and constants for pipelined MIPS datapath selectors.
package pipe_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Forwarding-select encodings shared by all operand-forwarding muxes
    localparam int unsigned FWD_REG   = 0;
    localparam int unsigned FWD_EXMEM = 1;
    localparam int unsigned FWD_MEMWB = 2;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 WIDTH-bit selector; flags selects at or beyond N_IN.
module mux_n
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      dout_c,
    output logic                  oor_c
);

    always_comb begin
        dout_c = '0;
        for (int k = 0; k < int'(N_IN); k++) begin
            if (sel == SEL_W'(k)) dout_c = din[k*WIDTH +: WIDTH];
        end
    end

    // Every encoding is legal when N_IN fills the select space
    if (is_pow2(N_IN)) begin : g_full
        assign oor_c = 1'b0;
    end else begin : g_partial
        assign oor_c = ({1'b0, sel} >= (SEL_W+1)'(N_IN));
    end

endmodule

// File: rtl/pipe_mux_reg.sv
// Registered N:1 pipeline-boundary selector with stall, flush, valid and sticky select-error capture.
module pipe_mux_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH     = DATA_W,
    parameter int unsigned N_IN      = 4,
    parameter logic [31:0] FLUSH_VAL = NOP_WORD,
    localparam int unsigned SEL_W    = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic [WIDTH-1:0]      dout,
    output logic                  out_valid,
    output logic                  sel_err,
    output logic [SEL_W-1:0]      err_sel
);

    localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(FLUSH_VAL);

    logic [WIDTH-1:0] w_mux;
    logic             w_oor;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_sel_err;
    logic [SEL_W-1:0] r_err_sel;

    mux_n #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_mux (
        .din    (din),
        .sel    (sel),
        .dout_c (w_mux),
        .oor_c  (w_oor)
    );

    // Priority: reset, flush, stall, load; error capture only on load cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout    <= BUBBLE;
            r_valid   <= 1'b0;
            r_sel_err <= 1'b0;
            r_err_sel <= '0;
        end else if (flush) begin
            r_dout    <= BUBBLE;
            r_valid   <= 1'b0;
        end else if (!stall) begin
            r_dout    <= w_oor ? BUBBLE : w_mux;
            r_valid   <= in_valid;
            if (w_oor && !r_sel_err) begin
                r_sel_err <= 1'b1;
                r_err_sel <= sel;
            end
        end
    end

    assign dout      = r_dout;
    assign out_valid = r_valid;
    assign sel_err   = r_sel_err;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_pipe_mux_reg.sv
// Scoreboard bench for pipe_mux_reg: a 4-input and a 3-input instance driven by directed vectors.
module tb_pipe_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst4, rst3;
    logic [127:0] din4;
    logic [95:0]  din3;
    logic [1:0]   sel4, sel3;
    logic         v4, v3, st4, st3, fl4, fl3;
    logic [31:0]  dout4, dout3;
    logic         ov4, ov3, se4, se3;
    logic [1:0]   es4, es3;

    pipe_mux_reg #(.WIDTH(32), .N_IN(4)) u_dut4 (
        .clk(clk), .reset(rst4), .din(din4), .sel(sel4), .in_valid(v4),
        .stall(st4), .flush(fl4), .dout(dout4), .out_valid(ov4),
        .sel_err(se4), .err_sel(es4)
    );

    pipe_mux_reg #(.WIDTH(32), .N_IN(3)) u_dut3 (
        .clk(clk), .reset(rst3), .din(din3), .sel(sel3), .in_valid(v3),
        .stall(st3), .flush(fl3), .dout(dout3), .out_valid(ov3),
        .sel_err(se3), .err_sel(es3)
    );

    typedef struct {
        bit          dut3;
        logic        valid;
        bit          chk_dout;
        logic [31:0] dout;
        logic        err;
        logic [1:0]  esel;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_step = 0;
    bit   cur3 = 1'b0;

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // Monitor: one expected record per clock edge, checked just after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.dut3) begin
                cmp("out_valid", e.id, 32'(ov3), 32'(e.valid));
                if (e.chk_dout) cmp("dout", e.id, dout3, e.dout);
                cmp("sel_err", e.id, 32'(se3), 32'(e.err));
                cmp("err_sel", e.id, 32'(es3), 32'(e.esel));
            end else begin
                cmp("out_valid", e.id, 32'(ov4), 32'(e.valid));
                if (e.chk_dout) cmp("dout", e.id, dout4, e.dout);
                cmp("sel_err", e.id, 32'(se4), 32'(e.err));
                cmp("err_sel", e.id, 32'(es4), 32'(e.esel));
            end
        end
    end

    // Drive one cycle of stimulus to the active instance and queue its expected result
    task automatic step(input logic rst, input logic [127:0] d, input logic [1:0] s,
                        input logic v, input logic st, input logic fl,
                        input logic e_v, input bit e_chk, input logic [31:0] e_d,
                        input logic e_err, input logic [1:0] e_es);
        exp_t e;
        @(negedge clk);
        if (cur3) begin
            rst3 = rst; din3 = d[95:0]; sel3 = s; v3 = v; st3 = st; fl3 = fl;
            rst4 = 1'b1;
        end else begin
            rst4 = rst; din4 = d; sel4 = s; v4 = v; st4 = st; fl4 = fl;
            rst3 = 1'b1;
        end
        n_step++;
        e.dut3 = cur3; e.valid = e_v; e.chk_dout = e_chk; e.dout = e_d;
        e.err = e_err; e.esel = e_es; e.id = n_step;
        exp_q.push_back(e);
    endtask

    localparam logic [127:0] D0 = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    localparam logic [127:0] D1 = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    localparam logic [127:0] D3 = {32'h0, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

    initial begin
        rst4 = 1'b1; rst3 = 1'b1; din4 = '0; din3 = '0; sel4 = '0; sel3 = '0;
        v4 = 1'b0; v3 = 1'b0; st4 = 1'b0; st3 = 1'b0; fl4 = 1'b0; fl3 = 1'b0;

        // N_IN=4: reset then load
        step(1, D0, 2, 1, 0, 0,  0, 1, 32'h0,          0, 0);
        step(1, D0, 2, 1, 0, 0,  0, 1, 32'h0,          0, 0);
        step(0, D0, 2, 1, 0, 0,  1, 1, 32'hCCCC_0002,  0, 0);
        // stall hold with changing din and sel
        step(0, D1, 0, 1, 1, 0,  1, 1, 32'hCCCC_0002,  0, 0);
        step(0, D1, 0, 0, 1, 0,  1, 1, 32'hCCCC_0002,  0, 0);
        step(0, D1, 0, 1, 1, 0,  1, 1, 32'hCCCC_0002,  0, 0);
        step(0, D0, 0, 1, 0, 0,  1, 1, 32'hAAAA_0000,  0, 0);
        // flush over stall, then load sel 3
        step(0, D0, 1, 1, 1, 1,  0, 1, 32'h0,          0, 0);
        step(0, D0, 3, 1, 0, 0,  1, 1, 32'hDDDD_0003,  0, 0);
        step(0, D1, 3, 1, 0, 1,  0, 1, 32'h0,          0, 0);
        step(0, D1, 3, 1, 0, 0,  1, 1, 32'h4444_0003,  0, 0);
        // valid tracking 1,0,1 then reset mid-sequence
        step(0, D0, 1, 1, 0, 0,  1, 1, 32'hBBBB_0001,  0, 0);
        step(0, D0, 2, 0, 0, 0,  0, 1, 32'hCCCC_0002,  0, 0);
        step(0, D0, 0, 1, 0, 0,  1, 1, 32'hAAAA_0000,  0, 0);
        step(1, D0, 3, 1, 1, 0,  0, 1, 32'h0,          0, 0);
        step(0, D1, 2, 1, 0, 0,  1, 1, 32'h3333_0002,  0, 0);

        // N_IN=3: illegal select ignored under stall and flush
        cur3 = 1'b1;
        step(1, D3, 0, 0, 0, 0,  0, 1, 32'h0,          0, 0);
        step(1, D3, 0, 0, 0, 0,  0, 1, 32'h0,          0, 0);
        step(0, D3, 3, 1, 1, 0,  0, 1, 32'h0,          0, 0);
        step(0, D3, 3, 1, 0, 1,  0, 1, 32'h0,          0, 0);
        step(0, D3, 1, 1, 0, 0,  1, 1, 32'hBBBB_0001,  0, 0);
        // out-of-range load sets sticky error
        step(0, D3, 3, 1, 0, 0,  1, 1, 32'h0,          1, 3);
        step(0, D3, 3, 1, 0, 0,  1, 1, 32'h0,          1, 3);
        step(0, D3, 1, 1, 0, 0,  1, 1, 32'hBBBB_0001,  1, 3);
        step(0, D3, 2, 1, 1, 1,  0, 1, 32'h0,          1, 3);
        step(0, D3, 2, 1, 0, 0,  1, 1, 32'hCCCC_0002,  1, 3);
        step(1, D3, 3, 1, 1, 1,  0, 1, 32'h0,          0, 0);
        step(0, D3, 0, 1, 0, 0,  1, 1, 32'hAAAA_0000,  0, 0);

        @(negedge clk);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
